// File: rtl/cop0_intc_if.sv
// cop0_intc_if: core-side bus of the COP0 interrupt controller (mtc0/mfc0, take/eret handshake)
interface cop0_intc_if;
   logic        stall;
   logic [4:0]  cp0_addr;
   logic        cp0_we;
   logic [31:0] cp0_wdata;
   logic [31:0] cp0_rdata;
   logic        irq_req;
   logic        irq_taken;
   logic [31:0] irq_epc_in;
   logic        eret;
   logic [31:0] epc_out;
   logic [31:0] vector_out;
   modport master (
      output stall, cp0_addr, cp0_we, cp0_wdata, irq_taken, irq_epc_in, eret,
      input  cp0_rdata, irq_req, epc_out, vector_out
   );
   modport slave (
      input  stall, cp0_addr, cp0_we, cp0_wdata, irq_taken, irq_epc_in, eret,
      output cp0_rdata, irq_req, epc_out, vector_out
   );
endinterface

// File: rtl/cop0_intc.sv
// cop0_intc: COP0 interrupt controller (STATUS/CAUSE/EPC); COP0_TIMER_EN adds COUNT/COMPARE timer
module cop0_intc #(
   parameter int          NUM_IRQ = 8,
   parameter logic [31:0] VECTOR  = 32'hC000_0000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_IRQ-1:0] irq_src,
   cop0_intc_if.slave         bus
);
`ifdef COP0_TIMER_EN
   localparam int NT = 1;
`else
   localparam int NT = 0;
`endif
   localparam int NM = NUM_IRQ + NT;
   logic [NUM_IRQ-1:0] s1_q, s1_d, s2_q, s2_d, prev_q, prev_d, ip_q, ip_d, edge_w;
   logic [NM-1:0]      im_q, im_d, pend;
   logic               ie_q, ie_d, exl_q, exl_d;
   logic [4:0]         exc_q, exc_d, win;
   logic [31:0]        epc_q, epc_d, status_w, cause_w, timer_rd;
   logic               wr, wr_st, wr_ca, wr_epc, take, ret;
   logic               unused_w;
   assign wr      = bus.cp0_we & ~bus.stall;
   assign wr_st   = wr & (bus.cp0_addr == 5'd12);
   assign wr_ca   = wr & (bus.cp0_addr == 5'd13);
   assign wr_epc  = wr & (bus.cp0_addr == 5'd14);
   assign edge_w  = s2_q & ~prev_q;
   assign bus.irq_req    = ie_q & ~exl_q & |(pend & im_q);
   assign take           = bus.irq_taken & ~bus.stall & bus.irq_req;
   assign ret            = bus.eret & ~bus.stall;
   assign bus.epc_out    = epc_q;
   assign bus.vector_out = VECTOR;
   assign unused_w       = ^{bus.cp0_wdata[31:8+NM], bus.cp0_wdata[7:2]};
`ifdef COP0_TIMER_EN
   logic [31:0] count_q, count_d, compare_q, compare_d;
   logic        tip_q, tip_d, wr_cnt, wr_cmp;
   assign wr_cnt = wr & (bus.cp0_addr == 5'd9);
   assign wr_cmp = wr & (bus.cp0_addr == 5'd11);
   assign pend   = {tip_q, ip_q};
   always_comb begin
      count_d   = wr_cnt ? bus.cp0_wdata : bus.stall ? count_q : count_q + 32'd1;
      compare_d = wr_cmp ? bus.cp0_wdata : compare_q;
      tip_d     = wr_cmp ? 1'b0 : tip_q | (count_q == compare_q);
      timer_rd  = (bus.cp0_addr == 5'd9) ? count_q : (bus.cp0_addr == 5'd11) ? compare_q : '0;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         count_q   <= '0;
         compare_q <= '0;
         tip_q     <= 1'b0;
      end else begin
         count_q   <= count_d;
         compare_q <= compare_d;
         tip_q     <= tip_d;
      end
`else
   assign pend     = ip_q;
   assign timer_rd = '0;
`endif
   // fixed priority: scanning downwards leaves the lowest set index
   always_comb begin
      win = '0;
      for (int i = NM - 1; i >= 0; i--)
         if (pend[i] & im_q[i]) win = 5'(i);
   end
   always_comb begin
      s1_d   = irq_src;
      s2_d   = s1_q;
      prev_d = s2_q;
      ip_d   = (ip_q & ~(wr_ca ? bus.cp0_wdata[8+:NUM_IRQ] : '0)) | edge_w;
      im_d   = wr_st ? bus.cp0_wdata[8+:NM] : im_q;
      ie_d   = take ? 1'b0 : wr_st ? bus.cp0_wdata[0] : ret ? 1'b1 : ie_q;
      exl_d  = take ? 1'b1 : wr_st ? bus.cp0_wdata[1] : ret ? 1'b0 : exl_q;
      exc_d  = take ? win : exc_q;
      epc_d  = take ? bus.irq_epc_in : wr_epc ? bus.cp0_wdata : epc_q;
      status_w         = '0;
      status_w[0]      = ie_q;
      status_w[1]      = exl_q;
      status_w[8+:NM]  = im_q;
      cause_w          = '0;
      cause_w[8+:NM]   = pend;
      cause_w[6:2]     = exc_q;
      bus.cp0_rdata = (bus.cp0_addr == 5'd12) ? status_w :
                      (bus.cp0_addr == 5'd13) ? cause_w  :
                      (bus.cp0_addr == 5'd14) ? epc_q    : timer_rd;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         s1_q   <= '0;
         s2_q   <= '0;
         prev_q <= '0;
         ip_q   <= '0;
         im_q   <= '0;
         ie_q   <= 1'b0;
         exl_q  <= 1'b0;
         exc_q  <= '0;
         epc_q  <= '0;
      end else begin
         s1_q   <= s1_d;
         s2_q   <= s2_d;
         prev_q <= prev_d;
         ip_q   <= ip_d;
         im_q   <= im_d;
         ie_q   <= ie_d;
         exl_q  <= exl_d;
         exc_q  <= exc_d;
         epc_q  <= epc_d;
      end
endmodule

// File: tb/tb_cop0_intc.sv
// tb_cop0_intc: directed scoreboard bench for cop0_intc
module tb_cop0_intc;
   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] irq_src;
   cop0_intc_if bus ();
   cop0_intc #(.NUM_IRQ(8), .VECTOR(32'hC000_0000)) dut (
      .clk(clk), .rst_n(rst_n), .irq_src(irq_src), .bus(bus)
   );
   always #50 clk = ~clk;
   int          checks = 0;
   int          errors = 0;
   string       tag_q[$];
   logic [31:0] exp_q[$];
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic push(input string t, input logic [31:0] e);
      tag_q.push_back(t);
      exp_q.push_back(e);
   endtask
   task automatic pop_cmp(input logic [31:0] obs);
      string       t;
      logic [31:0] e;
      if (exp_q.size() == 0) begin
         errors++;
         $error("FAIL scoreboard_empty observed=%h", obs);
         return;
      end
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      assert (obs === e) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", t, obs, e);
      end
   endtask
   task automatic rd(input logic [4:0] a, output logic [31:0] d);
      bus.cp0_addr = a;
      #1;
      d = bus.cp0_rdata;
   endtask
   task automatic chk_reg(input string t, input logic [4:0] a, input logic [31:0] e);
      logic [31:0] d;
      push(t, e);
      rd(a, d);
      pop_cmp(d);
   endtask
   task automatic chk_cause(input string t, input logic [31:0] e);
      logic [31:0] d;
      push(t, e);
      rd(5'd13, d);
      pop_cmp(d & 32'h0000_FFFF);
   endtask
   task automatic chk_req(input string t, input logic e);
      push(t, {31'b0, e});
      #1;
      pop_cmp({31'b0, bus.irq_req});
   endtask
   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      bus.cp0_we    = 1'b1;
      bus.cp0_addr  = a;
      bus.cp0_wdata = d;
      tick();
      bus.cp0_we    = 1'b0;
   endtask
   task automatic take(input logic [31:0] e);
      bus.irq_taken  = 1'b1;
      bus.irq_epc_in = e;
      tick();
      bus.irq_taken  = 1'b0;
   endtask
   initial begin
      int          n;
      logic [31:0] d;
      rst_n = 1'b0;
      irq_src = '0;
      bus.stall = 1'b0;
      bus.cp0_addr = '0;
      bus.cp0_we = 1'b0;
      bus.cp0_wdata = '0;
      bus.irq_taken = 1'b0;
      bus.irq_epc_in = '0;
      bus.eret = 1'b0;
      repeat (2) tick();
      chk_req("rst_req", 1'b0);
      chk_reg("rst_status", 5'd12, 32'h0);
      chk_reg("rst_cause", 5'd13, 32'h0);
      chk_reg("rst_epc", 5'd14, 32'h0);
      push("rst_epc_out", 32'h0);
      pop_cmp(bus.epc_out);
      push("vector", 32'hC000_0000);
      pop_cmp(bus.vector_out);
      rst_n = 1'b1;
      tick();
      wr(5'd12, 32'h0000_0201);
      chk_reg("t2_status", 5'd12, 32'h0000_0201);
      irq_src[1] = 1'b1;
      push("t2_req_k1", 32'h0);
      push("t2_req_k2", 32'h1);
      push("t2_cause", 32'h0000_0200);
      tick();
      tick();
      pop_cmp({31'b0, bus.irq_req});
      tick();
      pop_cmp({31'b0, bus.irq_req});
      rd(5'd13, d);
      pop_cmp(d & 32'h0000_FFFF);
      take(32'h1000_0040);
      chk_reg("t3_epc", 5'd14, 32'h1000_0040);
      push("t3_epc_out", 32'h1000_0040);
      pop_cmp(bus.epc_out);
      chk_reg("t3_status", 5'd12, 32'h0000_0202);
      chk_cause("t3_cause", 32'h0000_0204);
      chk_req("t3_req", 1'b0);
      wr(5'd13, 32'h0000_0200);
      repeat (3) tick();
      chk_cause("level_once", 32'h0000_0004);
      take(32'hDEAD_BEEF);
      chk_reg("take_ignored", 5'd14, 32'h1000_0040);
      irq_src = 8'h2A;
      wr(5'd12, 32'h0000_FF01);
      tick();
      tick();
      chk_req("t4_req", 1'b1);
      chk_cause("t4_cause", 32'h0000_2804);
      take(32'h0000_2000);
      chk_cause("t4_prio", 32'h0000_280C);
      chk_reg("t4_status", 5'd12, 32'h0000_FF02);
      wr(5'd13, 32'h0000_0800);
      chk_cause("t4_w1c", 32'h0000_200C);
      chk_req("t4_req_exl", 1'b0);
      bus.eret = 1'b1;
      tick();
      bus.eret = 1'b0;
      chk_reg("t4_eret_status", 5'd12, 32'h0000_FF01);
      chk_req("t4_rereq", 1'b1);
      irq_src = 8'h2E;
      tick();
      tick();
      bus.cp0_we = 1'b1;
      bus.cp0_addr = 5'd13;
      bus.cp0_wdata = 32'h0000_0400;
      tick();
      bus.cp0_we = 1'b0;
      chk_cause("t5_set_wins", 32'h0000_240C);
      bus.stall = 1'b1;
      bus.irq_taken = 1'b1;
      bus.irq_epc_in = 32'h0000_3000;
      irq_src = 8'h2F;
      repeat (3) tick();
      chk_reg("t5_stall_epc", 5'd14, 32'h0000_2000);
      chk_reg("t5_stall_status", 5'd12, 32'h0000_FF01);
      chk_cause("t5_stall_ip", 32'h0000_250C);
      bus.stall = 1'b0;
      bus.cp0_we = 1'b1;
      bus.cp0_addr = 5'd14;
      bus.cp0_wdata = 32'h0000_5555;
      tick();
      bus.cp0_we = 1'b0;
      bus.irq_taken = 1'b0;
      chk_reg("epc_coll", 5'd14, 32'h0000_3000);
      chk_reg("epc_coll_status", 5'd12, 32'h0000_FF02);
      chk_cause("epc_coll_cause", 32'h0000_2500);
      bus.eret = 1'b1;
      tick();
      bus.eret = 1'b0;
      chk_req("eret2_req", 1'b1);
      bus.irq_taken = 1'b1;
      bus.irq_epc_in = 32'h0000_4000;
      bus.eret = 1'b1;
      bus.cp0_we = 1'b1;
      bus.cp0_addr = 5'd12;
      bus.cp0_wdata = 32'h0000_0F03;
      tick();
      bus.irq_taken = 1'b0;
      bus.eret = 1'b0;
      bus.cp0_we = 1'b0;
      chk_reg("coll_status", 5'd12, 32'h0000_0F02);
      chk_reg("coll_epc", 5'd14, 32'h0000_4000);
      wr(5'd3, 32'hFFFF_FFFF);
      chk_reg("unmapped", 5'd3, 32'h0);
      chk_reg("unmapped_status", 5'd12, 32'h0000_0F02);
`ifdef COP0_TIMER_EN
      wr(5'd12, 32'h0001_0001);
      chk_reg("t6_status", 5'd12, 32'h0001_0001);
      wr(5'd9, 32'h0);
      wr(5'd11, 32'd20);
      chk_req("t6_req_early", 1'b0);
      n = 0;
      while (!bus.irq_req && n < 60) begin
         tick();
         n++;
      end
      chk_req("t6_req", 1'b1);
      push("t6_cycles", 32'd20);
      pop_cmp(32'(n));
      push("t6_tip", 32'h0001_0000);
      rd(5'd13, d);
      pop_cmp(d & 32'h0001_0000);
      wr(5'd11, 32'hFFFF_FF00);
      chk_req("t6_cmp_clear", 1'b0);
      wr(5'd9, 32'hFFFF_FFFE);
      chk_reg("t6_count", 5'd9, 32'hFFFF_FFFE);
      tick();
      tick();
      chk_reg("t6_wrap", 5'd9, 32'h0);
`endif
      wr(5'd12, 32'h0000_0F01);
      chk_req("t1_pre_req", 1'b1);
      #10;
      rst_n = 1'b0;
      irq_src = '0;
      chk_req("t1_req", 1'b0);
      chk_reg("t1_status", 5'd12, 32'h0);
      chk_reg("t1_cause", 5'd13, 32'h0);
      chk_reg("t1_epc", 5'd14, 32'h0);
      push("t1_epc_out", 32'h0);
      pop_cmp(bus.epc_out);
      tick();
      rst_n = 1'b1;
      repeat (4) tick();
      chk_cause("t1_lost", 32'h0);
      chk_req("t1_post_req", 1'b0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
